// File: rtl/imem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter_pkg
// Description : Shared constants for the instruction-memory arbiter: memory
//               geometry, the NOP opcode, controller state encodings and an
//               address range-check helper.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_arbiter_pkg;

    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 1024;
    localparam int IMEM_DATA_W = 16;

    localparam logic [IMEM_DATA_W-1:0] IMEM_NOP = 16'h0000;

    localparam logic [1:0] ST_HALT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // A word address is usable only below the implemented depth; the upper
    // address bits take part in the check so aliased addresses are caught.
    function automatic logic addr_in_range(input logic [15:0] addr, input int depth);
        logic [31:0] w_addr;
        w_addr = {16'b0, addr};
        return (w_addr < 32'(depth));
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter_if
// Description : Bundles the host port, CPU fetch port and memory port of the
//               instruction-memory arbiter. slave = arbiter side,
//               master = the surrounding system (host, CPU, memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_arbiter_if
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
);
    // Host program-load / debug port
    logic                   host_run;
    logic                   host_halt;
    logic                   host_req;
    logic                   host_we;
    logic [15:0]            host_addr;
    logic [15:0]            host_wdata;
    logic                   host_gnt;
    logic                   host_rvalid;
    logic [15:0]            host_rdata;
    logic                   host_rerr;

    // CPU fetch port
    logic [15:0]            cpu_pc;
    logic [15:0]            cpu_op;
    logic                   cpu_stall;
    logic                   cpu_rst_n;
    logic                   cpu_fault;

    // Memory port
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_we;
    logic [15:0]            mem_wdata;
    logic [15:0]            mem_rdata;

    modport slave (
        input  host_run, host_halt, host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata, host_rerr,
        input  cpu_pc,
        output cpu_op, cpu_stall, cpu_rst_n, cpu_fault,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output host_run, host_halt, host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata, host_rerr,
        output cpu_pc,
        input  cpu_op, cpu_stall, cpu_rst_n, cpu_fault,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/imem_host_port.sv
`default_nettype none
// ============================================================================
// Module      : imem_host_port
// Description : Host-side range check and registered read response. Every
//               host transfer produces a one-cycle rvalid pulse in the next
//               cycle; rdata carries memory data only for in-range reads.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_host_port
    import imem_arbiter_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_xfer,
    input  wire logic        i_we,
    input  wire logic [15:0] i_addr,
    input  wire logic [15:0] i_mem_rdata,
    output logic             o_in_range,
    output logic             o_rvalid,
    output logic [15:0]      o_rdata,
    output logic             o_rerr
);

    logic        r_rvalid;
    logic [15:0] r_rdata;
    logic        r_rerr;
    logic        w_in_range;

    assign w_in_range = addr_in_range(i_addr, DEPTH);

    // Capture the response of the transfer granted in this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rerr   <= 1'b0;
        end else begin
            r_rvalid <= i_xfer;
            r_rerr   <= i_xfer & ~w_in_range;
            r_rdata  <= (i_xfer & ~i_we & w_in_range) ? i_mem_rdata : '0;
        end
    end

    assign o_in_range = w_in_range;
    assign o_rvalid   = r_rvalid;
    assign o_rdata    = r_rdata;
    assign o_rerr     = r_rerr;

endmodule
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Single-port access controller for the instruction memory.
//               HALT holds the CPU in reset and gives the host the port; RUN
//               lets the host steal at most MAX_STEAL consecutive cycles
//               before the CPU gets one; an out-of-range CPU fetch traps to
//               FAULT with a sticky cpu_fault flag.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int          ADDR_W    = IMEM_ADDR_W,
    parameter int          DEPTH     = IMEM_DEPTH,
    parameter int          MAX_STEAL = 4,
    parameter logic [15:0] NOP       = IMEM_NOP
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    imem_arbiter_if.slave  bus
);

    localparam int             CNT_W       = $clog2(MAX_STEAL + 1);
    localparam logic [CNT_W-1:0] C_MAX_STEAL = CNT_W'(MAX_STEAL);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_steal_cnt;
    logic [CNT_W-1:0] w_steal_next;
    logic             r_cpu_rst_n;
    logic             r_cpu_fault;

    logic             w_run;
    logic             w_host_gnt;
    logic             w_xfer;
    logic             w_host_in_range;
    logic             w_pc_in_range;
    logic             w_cpu_fetch;

    assign w_run = (r_state == ST_RUN);

    // Outside RUN the host owns the port outright, so any request is granted;
    // in RUN the steal budget decides.
    assign w_host_gnt    = w_run ? (bus.host_req & (r_steal_cnt < C_MAX_STEAL))
                                 : bus.host_req;
    assign w_xfer        = bus.host_req & w_host_gnt;
    assign w_pc_in_range = addr_in_range(bus.cpu_pc, DEPTH);
    assign w_cpu_fetch   = w_run & ~w_xfer;

    // Next-state decode; halt has priority over run in every state.
    always_comb begin
        w_next_state = r_state;
        if (bus.host_halt) begin
            w_next_state = ST_HALT;
        end else begin
            case (r_state)
                ST_HALT:  if (bus.host_run) w_next_state = ST_RUN;
                ST_RUN:   if (w_cpu_fetch & ~w_pc_in_range) w_next_state = ST_FAULT;
                ST_FAULT: w_next_state = ST_FAULT;
                default:  w_next_state = ST_HALT;
            endcase
        end
    end

    // Steal counter: counts consecutive RUN host transfers, cleared by a CPU
    // cycle or any state change.
    always_comb begin
        w_steal_next = '0;
        if (w_run && w_xfer && (w_next_state == r_state)) begin
            w_steal_next = (r_steal_cnt == C_MAX_STEAL) ? r_steal_cnt
                                                       : r_steal_cnt + CNT_W'(1);
        end
    end

    // State, steal counter and the registered CPU control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HALT;
            r_steal_cnt <= '0;
            r_cpu_rst_n <= 1'b0;
            r_cpu_fault <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_steal_cnt <= w_steal_next;
            r_cpu_rst_n <= (w_next_state != ST_HALT);
            r_cpu_fault <= (w_next_state == ST_FAULT);
        end
    end

    // Memory port mux: the host wins the address only on a granted transfer.
    assign bus.mem_addr  = w_xfer ? bus.host_addr[ADDR_W-1:0] : bus.cpu_pc[ADDR_W-1:0];
    assign bus.mem_wdata = bus.host_wdata;
    assign bus.mem_we    = w_xfer & bus.host_we & w_host_in_range;

    assign bus.host_gnt  = w_host_gnt;

    // CPU sees memory data only on its own in-range fetch cycles.
    assign bus.cpu_op    = (w_cpu_fetch & w_pc_in_range) ? bus.mem_rdata : NOP;
    assign bus.cpu_stall = ~w_run | w_xfer | ~w_pc_in_range;
    assign bus.cpu_rst_n = r_cpu_rst_n;
    assign bus.cpu_fault = r_cpu_fault;

    imem_host_port #(
        .DEPTH       (DEPTH)
    ) u_host_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_xfer      (w_xfer),
        .i_we        (bus.host_we),
        .i_addr      (bus.host_addr),
        .i_mem_rdata (bus.mem_rdata),
        .o_in_range  (w_host_in_range),
        .o_rvalid    (bus.host_rvalid),
        .o_rdata     (bus.host_rdata),
        .o_rerr      (bus.host_rerr)
    );

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_arbiter
// Description : Self-checking bench for imem_arbiter with a 1024x16 memory
//               model (combinational read, synchronous write). One table row
//               is one clock cycle of stimulus plus expected outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    logic clk;
    logic rst_n;

    imem_arbiter_if #(.ADDR_W(10)) bus ();

    imem_arbiter #(
        .ADDR_W    (10),
        .DEPTH     (1024),
        .MAX_STEAL (4),
        .NOP       (16'h0000)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Instruction memory model
    logic [15:0] mem [0:1023];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run, halt, req, we;
        logic [15:0] addr, wdata, pc;
        logic        cg;            // 1 = compare host_gnt
        logic        gnt, mwe;
        logic [15:0] op;
        logic        stall, crst, flt, rv;
        logic [15:0] rd;
        logic        re;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(
        input logic run, halt, req, we, input logic [15:0] addr, wdata, pc,
        input logic cg, gnt, mwe, input logic [15:0] op,
        input logic stall, crst, flt, rv, input logic [15:0] rd, input logic re);
        vec_t v;
        v.run = run; v.halt = halt; v.req = req; v.we = we;
        v.addr = addr; v.wdata = wdata; v.pc = pc;
        v.cg = cg; v.gnt = gnt; v.mwe = mwe; v.op = op;
        v.stall = stall; v.crst = crst; v.flt = flt; v.rv = rv;
        v.rd = rd; v.re = re;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.host_run   = v.run;
        bus.host_halt  = v.halt;
        bus.host_req   = v.req;
        bus.host_we    = v.we;
        bus.host_addr  = v.addr;
        bus.host_wdata = v.wdata;
        bus.cpu_pc     = v.pc;
    endtask

    initial begin
        logic [38:0] act, exp;
        logic        g, pg;

        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;

        // ---- Build the vector table -------------------------------------
        //                 run hlt req we addr      wdata     pc        cg gnt mwe op        st rn fl rv rd        re
        // HALT: write 0, read 0, response, write 5
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h6603, 16'h0000, 1, 1, 1, 16'h0000, 1, 0, 0, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 0, 1, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h6603, 0));
        vecs.push_back(mk(0, 0, 1, 1, 16'h0005, 16'h1234, 16'h0000, 1, 1, 1, 16'h0000, 1, 0, 0, 0, 16'h0000, 0));
        // run pulse, then first CPU fetch from PC 5
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0005, 1, 0, 0, 16'h1234, 0, 1, 0, 0, 16'h0000, 0));
        // 12 cycles of held host reads: grant 1111_0_1111_0_11
        pg = 1'b0;
        for (int k = 0; k < 12; k++) begin
            g = ((k % 5) != 4);
            vecs.push_back(mk(0, 0, 1, 0, 16'h0005, 16'h0000, 16'h0005, 1, g, 0,
                              g ? 16'h0000 : 16'h1234, g, 1, 0, pg,
                              pg ? 16'h1234 : 16'h0000, 0));
            pg = g;
        end
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0005, 1, 0, 0, 16'h1234, 0, 1, 0, 1, 16'h1234, 0));
        // out-of-range host write, then readback of addr 0
        vecs.push_back(mk(0, 0, 1, 1, 16'h0400, 16'hFFFF, 16'h0005, 1, 1, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0005, 1, 1, 0, 16'h0000, 1, 1, 0, 1, 16'h0000, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0005, 1, 0, 0, 16'h1234, 0, 1, 0, 1, 16'h6603, 0));
        // out-of-range fetch -> FAULT; host still served; halt
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0400, 1, 0, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0005, 16'h0000, 16'h0400, 1, 1, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0400, 0, 0, 0, 16'h0000, 1, 1, 1, 1, 16'h1234, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0));
        // run and halt together: stays HALT
        vecs.push_back(mk(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0));
        // restart: CPU fetches PC 0
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 16'h6603, 0, 1, 0, 0, 16'h0000, 0));

        // ---- Reset values ------------------------------------------------
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0));
        #2;
        chk("reset_outputs",
            {25'b0, bus.mem_we, bus.cpu_op, bus.cpu_stall, bus.cpu_rst_n, bus.cpu_fault,
             bus.host_rvalid, bus.host_rdata, bus.host_rerr},
            {25'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0});
        bus.host_req = 1'b1;
        #1;
        chk("reset_gnt_follows_req", {63'b0, bus.host_gnt}, 64'd1);
        bus.host_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---- Table-driven cycles ----------------------------------------
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            act = {vecs[i].cg ? bus.host_gnt : vecs[i].gnt, bus.mem_we, bus.cpu_op,
                   bus.cpu_stall, bus.cpu_rst_n, bus.cpu_fault, bus.host_rvalid,
                   bus.host_rdata, bus.host_rerr};
            exp = {vecs[i].gnt, vecs[i].mwe, vecs[i].op, vecs[i].stall, vecs[i].crst,
                   vecs[i].flt, vecs[i].rv, vecs[i].rd, vecs[i].re};
            chk($sformatf("vec%0d {gnt,we,op,stall,crstn,flt,rv,rd,re}", i),
                {25'b0, act}, {25'b0, exp});
            @(posedge clk);
            #1;
        end

        // ---- Asynchronous reset in RUN with a response pending ----------
        drive(mk(0, 0, 1, 0, 16'h0000, 16'h0, 16'h0000, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0));
        @(negedge clk);
        chk("run_read_granted", {62'b0, bus.host_gnt, bus.cpu_stall}, 64'd3);
        @(posedge clk);
        #2;
        chk("run_read_response", {47'b0, bus.host_rvalid, bus.host_rdata}, {47'b0, 1'b1, 16'h6603});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {44'b0, bus.cpu_rst_n, bus.host_rvalid, bus.host_rdata, bus.cpu_stall, bus.cpu_fault},
            {44'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        bus.host_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_halt", {62'b0, bus.cpu_rst_n, bus.cpu_stall}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
